// File: rtl/wh_bram_rd_arbiter_if.sv
// Request/response and BRAM port-B bundle for the WH BRAM read arbiter.
// The arbiter takes the slave view; requesters plus the BRAM sit on the master side.
interface wh_bram_rd_arbiter_if #(
   parameter int NUM_REQ         = 2,
   parameter int BRAM_ADDR_WIDTH = 32,
   parameter int WH_BRAM_WIDTH   = 137
);
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]                 req_last;
   logic [NUM_REQ-1:0]                 rsp_valid;
   logic [WH_BRAM_WIDTH-1:0]           rsp_data;
   logic [WH_BRAM_WIDTH-1:0]           WH_BRAM_dout;
   logic                               WH_BRAM_enb;
   logic [BRAM_ADDR_WIDTH-1:0]         WH_BRAM_addrb;

   modport slave (
      input  req_valid, req_addr, req_last, WH_BRAM_dout,
      output req_ready, rsp_valid, rsp_data, WH_BRAM_enb, WH_BRAM_addrb
   );

   modport master (
      output req_valid, req_addr, req_last, WH_BRAM_dout,
      input  req_ready, rsp_valid, rsp_data, WH_BRAM_enb, WH_BRAM_addrb
   );
endinterface

// File: rtl/wh_bram_rd_arbiter.sv
// Round-robin, burst-locked arbiter sharing WH BRAM read port B between NUM_REQ requesters.
// A tag pipeline matched to RD_LATENCY steers each returning word to the requester that issued it.
module wh_bram_rd_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int BRAM_ADDR_WIDTH = 32,
   parameter int WH_BRAM_WIDTH   = 137,
   parameter int RD_LATENCY      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   wh_bram_rd_arbiter_if.slave     bus,
   output logic                    busy_o
);
   localparam int OWN_W = $clog2(NUM_REQ);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                     state_r, state_nxt_s;
   logic [OWN_W-1:0]           owner_r, owner_nxt_s;
   logic [OWN_W-1:0]           rr_ptr_r, rr_ptr_nxt_s;
   logic [OWN_W-1:0]           winner_s;
   logic                       accept_s, last_beat_s;
   logic [NUM_REQ-1:0]         ready_s, rsp_onehot_s;
   logic                       enb_s;
   logic [BRAM_ADDR_WIDTH-1:0] addrb_s, addrb_r;
   logic [RD_LATENCY-1:0]      tag_vld_r;
   logic [OWN_W-1:0]           tag_own_r [RD_LATENCY];
   logic [NUM_REQ-1:0]         rsp_valid_r;
   logic [WH_BRAM_WIDTH-1:0]   rsp_data_r;

   // Scan downward so the lowest offset from ptr is the last (winning) assignment.
   function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [OWN_W-1:0]   ptr);
      logic [OWN_W-1:0] pick;
      int               idx;
      pick = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (vld[OWN_W'(idx)]) begin
            pick = OWN_W'(idx);
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   assign winner_s    = rr_pick(bus.req_valid, rr_ptr_r);
   assign accept_s    = (state_r == GRANT) && bus.req_valid[owner_r];
   assign last_beat_s = accept_s && bus.req_last[owner_r];

   // FSM state, owner and round-robin pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         owner_r  <= '0;
         rr_ptr_r <= '0;
         addrb_r  <= '0;
      end else begin
         state_r  <= state_nxt_s;
         owner_r  <= owner_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
         addrb_r  <= addrb_s;
      end
   end

   // Next-state logic: arbitrate in IDLE, hold the grant until the owner's last beat
   always_comb begin
      state_nxt_s  = state_r;
      owner_nxt_s  = owner_r;
      rr_ptr_nxt_s = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (|bus.req_valid) begin
               owner_nxt_s = winner_s;
               state_nxt_s = GRANT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            if (last_beat_s) begin
               rr_ptr_nxt_s = OWN_W'((int'(owner_r) + 1) % NUM_REQ);
               state_nxt_s  = IDLE;
            end else begin
               state_nxt_s = GRANT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Output logic: ready to the owner only; BRAM enable/address follow the accepted beat
   always_comb begin
      ready_s = '0;
      enb_s   = 1'b0;
      addrb_s = addrb_r;
      if (state_r == GRANT) begin
         ready_s[owner_r] = 1'b1;
      end else begin
         ready_s = '0;
      end
      if (accept_s) begin
         enb_s   = 1'b1;
         addrb_s = bus.req_addr[int'(owner_r)*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
      end else begin
         enb_s   = 1'b0;
      end
   end

   // Tag pipeline: one {valid, owner} stage per cycle of BRAM read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_r <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_own_r[i] <= '0;
         end
      end else begin
         tag_vld_r[0] <= accept_s;
         tag_own_r[0] <= owner_r;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_r[i] <= tag_vld_r[i-1];
            tag_own_r[i] <= tag_own_r[i-1];
         end
      end
   end

   // One-hot steering of the word leaving the final tag stage
   always_comb begin
      rsp_onehot_s = '0;
      if (tag_vld_r[RD_LATENCY-1]) begin
         rsp_onehot_s[tag_own_r[RD_LATENCY-1]] = 1'b1;
      end else begin
         rsp_onehot_s = '0;
      end
   end

   // Response flop; data holds between responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
      end else begin
         rsp_valid_r <= rsp_onehot_s;
         if (tag_vld_r[RD_LATENCY-1]) begin
            rsp_data_r <= bus.WH_BRAM_dout;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end
   end

   assign bus.req_ready     = ready_s;
   assign bus.WH_BRAM_enb   = enb_s;
   assign bus.WH_BRAM_addrb = addrb_s;
   assign bus.rsp_valid     = rsp_valid_r;
   assign bus.rsp_data      = rsp_data_r;
   assign busy_o            = (state_r == GRANT) || (|tag_vld_r);
endmodule
